// File: rtl/highest_set_pkg.sv
// Shared types and pipeline-placement helpers for the highest-set priority encoder.
// Latency: none (package only).
// Backpressure: not applicable.
package highest_set_pkg;

    typedef enum logic {
        HS_VALUE  = 1'b0,
        HS_REGIME = 1'b1
    } hs_mode_t;

    // Tree level whose output is captured by register rank 'rank' (1-based).
    // Ranks are spread evenly over the $clog2(n) merge levels; the last rank lands on the root.
    function automatic int hs_stage_levels(input int n, input int stages, input int rank);
        return (rank * $clog2(n)) / stages;
    endfunction

    // True when an intermediate (non-output) rank sits directly after tree level 'lvl'.
    function automatic bit hs_rank_after(input int n, input int stages, input int lvl);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k < stages; k++) begin
            if (hs_stage_levels(n, stages, k) == lvl) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/highest_set_pipe_merge.sv
// 2:1 reduction node: keeps the higher half's hit when present, else the lower half's.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module hs_merge_node #(
    parameter int W   = 4,
    parameter int LVL = 1
) (
    input  logic         f_hi,
    input  logic [W-1:0] i_hi,
    input  logic         f_lo,
    input  logic [W-1:0] i_lo,
    output logic         f,
    output logic [W-1:0] i
);
    // Indices are carried zero-extended at full width; setting bit LVL-1 is the
    // same as prepending the 'upper half' bit to the child's local index.
    localparam logic [W-1:0] SEL = W'(1) << (LVL - 1);

    assign f = f_hi | f_lo;
    assign i = f_hi ? (i_hi | SEL) : i_lo;
endmodule

// File: rtl/highest_set_pipe.sv
// Pipelined priority encoder: highest index matching val (VALUE) or differing from the MSB (REGIME).
// Latency: STAGES cycles from acceptance to out_valid when not stalled; 1 beat/cycle.
// Backpressure: global stall; every rank and the outputs hold while out_valid && !out_ready.
module highest_set_pipe
    import highest_set_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         bits,
    input  logic                 val,
    input  hs_mode_t             mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 found,
    output logic [$clog2(N)-1:0] index,
    output logic [$clog2(N):0]   run_len
);
    localparam int LOG = $clog2(N);
    localparam int RW  = LOG + 1;

    logic              w_adv;
    logic [STAGES:1]   r_vld;
    logic              w_found;
    logic [LOG-1:0]    w_index;
    logic [RW-1:0]     w_run_len;
    logic              r_found;
    logic [LOG-1:0]    r_index;
    logic [RW-1:0]     r_run_len;

    assign w_adv     = !r_vld[STAGES] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES];
    assign found     = r_found;
    assign index     = r_index;
    assign run_len   = r_run_len;

    // Valid bits shift one rank per advance; an idle input enters as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    genvar gl, gj;
    generate
        for (gl = 0; gl <= LOG; gl++) begin : g_lvl
            localparam int NODES = N >> gl;
            logic [NODES-1:0]          w_f;
            logic [NODES-1:0][LOG-1:0] w_i;
            logic [NODES-1:0]          w_sf;
            logic [NODES-1:0][LOG-1:0] w_si;

            if (gl == 0) begin : g_leaf
                // REGIME compares each bit with the sign bit, so bit N-1 never qualifies.
                for (gj = 0; gj < N; gj++) begin : g_bit
                    assign w_f[gj] = (mode == HS_REGIME) ? (bits[gj] != bits[N-1])
                                                         : (bits[gj] == val);
                end
                assign w_i = '0;
            end else begin : g_node
                for (gj = 0; gj < NODES; gj++) begin : g_m
                    hs_merge_node #(.W(LOG), .LVL(gl)) u_merge (
                        .f_hi (g_lvl[gl-1].w_sf[2*gj+1]),
                        .i_hi (g_lvl[gl-1].w_si[2*gj+1]),
                        .f_lo (g_lvl[gl-1].w_sf[2*gj]),
                        .i_lo (g_lvl[gl-1].w_si[2*gj]),
                        .f    (w_f[gj]),
                        .i    (w_i[gj])
                    );
                end
            end

            if (gl > 0 && gl < LOG && hs_rank_after(N, STAGES, gl)) begin : g_rank
                logic [NODES-1:0]          r_f;
                logic [NODES-1:0][LOG-1:0] r_i;

                // Intermediate rank: captures this level's partial results on every advance.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_f <= '0;
                        r_i <= '0;
                    end else if (w_adv) begin
                        r_f <= w_f;
                        r_i <= w_i;
                    end
                end
                assign w_sf = r_f;
                assign w_si = r_i;
            end else begin : g_pass
                assign w_sf = w_f;
                assign w_si = w_i;
            end
        end
    endgenerate

    // No hit forces index to all-ones and run_len to N; otherwise run_len counts bits above index.
    assign w_found   = g_lvl[LOG].w_sf[0];
    assign w_index   = w_found ? g_lvl[LOG].w_si[0] : '1;
    assign w_run_len = w_found ? (RW'(N - 1) - {1'b0, w_index}) : RW'(N);

    // Output rank: loads the finished result on every advance, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found   <= 1'b0;
            r_index   <= '1;
            r_run_len <= RW'(N);
        end else if (w_adv) begin
            r_found   <= w_found;
            r_index   <= w_index;
            r_run_len <= w_run_len;
        end
    end
endmodule

// File: tb/tb_highest_set_pipe.sv
// Bench for highest_set_pipe: N=8/STAGES=2 directed scenarios plus N=32/STAGES=5 random traffic.
// Latency: checked against STAGES plus counted stall cycles.
// Backpressure: exercised through out_ready holds and random stalls.
module tb_highest_set_pipe;
    import highest_set_pkg::*;

    typedef struct {
        logic f;
        int   idx;
        int   rl;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       in_valid8, in_ready8, val8, out_valid8, out_ready8, found8;
    hs_mode_t   mode8;
    logic [7:0] bits8;
    logic [2:0] index8;
    logic [3:0] run_len8;

    logic        in_valid32, in_ready32, val32, out_valid32, out_ready32, found32;
    hs_mode_t    mode32;
    logic [31:0] bits32;
    logic [4:0]  index32;
    logic [5:0]  run_len32;

    highest_set_pipe #(.N(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .bits(bits8), .val(val8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .found(found8), .index(index8), .run_len(run_len8)
    );

    highest_set_pipe #(.N(32), .STAGES(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .bits(bits32), .val(val32), .mode(mode32), .out_valid(out_valid32),
        .out_ready(out_ready32), .found(found32), .index(index32), .run_len(run_len32)
    );

    int   checks = 0;
    int   errors = 0;
    res_t q8[$];
    res_t q32[$];
    int   q32_cyc[$];
    int   q32_stl[$];
    int   cyc8 = 0;

    logic       g_rdy, g_out, g_ov, g_f;
    logic [2:0] g_i;
    logic [3:0] g_r;

    // Reference: scan from the top for the first qualifying bit.
    function automatic res_t model(input logic [31:0] b, input logic v, input logic m, input int n);
        res_t r;
        logic q;
        r.f = 1'b0; r.idx = n - 1; r.rl = n;
        for (int i = n - 1; i >= 0; i--) begin
            if (m) q = (i != n - 1) && (b[i] != b[n-1]);
            else   q = (b[i] == v);
            if (q && !r.f) begin
                r.f = 1'b1; r.idx = i; r.rl = n - 1 - i;
            end
        end
        return r;
    endfunction

    // One N=8 clock: drive at negedge, sample 1 time unit later, queue accepted beats.
    task automatic cycle8(input logic iv, input logic [7:0] b, input logic v, input logic m, input logic ordy);
        @(negedge clk);
        in_valid8 = iv; bits8 = b; val8 = v; mode8 = hs_mode_t'(m); out_ready8 = ordy;
        #1;
        g_rdy = in_ready8; g_ov = out_valid8; g_out = out_valid8 && out_ready8;
        g_f = found8; g_i = index8; g_r = run_len8;
        if (iv && in_ready8) q8.push_back(model(32'(b), v, m, 8));
        cyc8++;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = 1'b0; bits8 = '0; val8 = 1'b0; mode8 = HS_VALUE; out_ready8 = 1'b1;
        in_valid32 = 1'b0; bits32 = '0; val32 = 1'b0; mode32 = HS_VALUE; out_ready32 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
        checks++; if (found8 !== 1'b0) begin errors++; $display("FAIL reset_found got %b want 0", found8); end
        checks++; if (index8 !== 3'd7) begin errors++; $display("FAIL reset_index got %0d want 7", index8); end
        checks++; if (run_len8 !== 4'd8) begin errors++; $display("FAIL reset_run_len got %0d want 8", run_len8); end
        checks++; if (run_len32 !== 6'd32) begin errors++; $display("FAIL reset_run_len32 got %0d want 32", run_len32); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32 got %b want 0", out_valid32); end
    endtask

    task automatic test_basic();
        int lat;
        res_t e;
        cycle8(1'b1, 8'b0000_1001, 1'b1, 1'b0, 1'b1);
        checks++; if (g_rdy !== 1'b1) begin errors++; $display("FAIL basic_accept got %b want 1", g_rdy); end
        lat = 0;
        do begin
            cycle8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            lat++;
        end while (!g_out && lat < 10);
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
        checks++; if ({g_f, g_i, g_r} !== {1'b1, 3'd3, 4'd4}) begin
            errors++; $display("FAIL basic_result got f=%b i=%0d r=%0d want f=1 i=3 r=4", g_f, g_i, g_r);
        end
        if (q8.size() > 0) e = q8.pop_front();
    endtask

    task automatic test_patterns();
        logic [7:0] tb_bits [8] = '{8'hFF, 8'b0001_0110, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'h7F};
        logic       tb_val  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       tb_mode [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        res_t e;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) cycle8(1'b1, tb_bits[c], tb_val[c], tb_mode[c], 1'b1);
            else       cycle8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (g_out) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL pat_unexpected got i=%0d want no output", g_i);
                end else begin
                    e = q8.pop_front();
                    if ({g_f, g_i, g_r} !== {e.f, 3'(e.idx), 4'(e.rl)}) begin
                        errors++;
                        $display("FAIL pat_result got f=%b i=%0d r=%0d want f=%b i=%0d r=%0d", g_f, g_i, g_r, e.f, e.idx, e.rl);
                    end
                end
            end
        end
        checks++; if (q8.size() != 0) begin errors++; $display("FAIL pat_drain got %0d pending want 0", q8.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b2b [4] = '{8'h01, 8'h03, 8'h30, 8'hC0};
        logic [2:0] exp_i [4] = '{3'd0, 3'd1, 3'd5, 3'd7};
        int n_out, first;
        res_t e;
        n_out = 0; first = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                cycle8(1'b1, b2b[c], 1'b1, 1'b0, 1'b1);
                checks++; if (g_rdy !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", g_rdy); end
            end else begin
                cycle8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            end
            if (g_out && q8.size() > 0) begin
                e = q8.pop_front();
                if (n_out == 0) first = cyc8;
                checks++; if (g_i !== exp_i[n_out % 4] || g_f !== 1'b1) begin
                    errors++; $display("FAIL b2b_index got %0d want %0d", g_i, exp_i[n_out % 4]);
                end
                checks++; if (cyc8 != first + n_out) begin
                    errors++; $display("FAIL b2b_spacing got cycle %0d want %0d", cyc8, first + n_out);
                end
                n_out++;
            end
        end
        checks++; if (n_out != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n_out); end
    endtask

    task automatic test_stall();
        logic [7:0] beats [2] = '{8'h12, 8'h24};
        logic       s_f;
        logic [2:0] s_i;
        logic [3:0] s_r;
        int p, n_out, first;
        res_t e;
        p = 0;
        for (int c = 0; c < 3; c++) begin
            cycle8(p < 2, (p < 2) ? beats[p] : 8'h00, 1'b1, 1'b0, 1'b0);
            if (p < 2 && g_rdy) p++;
        end
        s_f = g_f; s_i = g_i; s_r = g_r;
        checks++; if (g_ov !== 1'b1) begin errors++; $display("FAIL stall_full got out_valid %b want 1", g_ov); end
        for (int c = 0; c < 5; c++) begin
            cycle8(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
            checks++; if (g_rdy !== 1'b0 || g_ov !== 1'b1) begin
                errors++; $display("FAIL stall_hold got in_ready=%b out_valid=%b want 0/1", g_rdy, g_ov);
            end
            checks++; if ({g_f, g_i, g_r} !== {s_f, s_i, s_r}) begin
                errors++; $display("FAIL stall_stable got i=%0d r=%0d want i=%0d r=%0d", g_i, g_r, s_i, s_r);
            end
        end
        n_out = 0; first = 0;
        for (int c = 0; c < 8; c++) begin
            cycle8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (g_out) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL stall_extra got i=%0d want no output", g_i);
                end else begin
                    e = q8.pop_front();
                    if (n_out == 0) first = cyc8;
                    if ({g_f, g_i, g_r} !== {e.f, 3'(e.idx), 4'(e.rl)} || cyc8 != first + n_out) begin
                        errors++; $display("FAIL stall_release got i=%0d r=%0d cyc=%0d want i=%0d r=%0d cyc=%0d",
                                           g_i, g_r, cyc8, e.idx, e.rl, first + n_out);
                    end
                    n_out++;
                end
            end
        end
        checks++; if (n_out != 2 || q8.size() != 0) begin
            errors++; $display("FAIL stall_count got %0d outputs %0d pending want 2/0", n_out, q8.size());
        end
    endtask

    task automatic test_reset_flight();
        int n_out;
        res_t e;
        cycle8(1'b1, 8'h0F, 1'b1, 1'b0, 1'b1);
        cycle8(1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid8 = 1'b0;
        #1;
        checks++; if ({out_valid8, found8, index8, run_len8} !== {1'b0, 1'b0, 3'd7, 4'd8}) begin
            errors++; $display("FAIL rst_flight got v=%b f=%b i=%0d r=%0d want v=0 f=0 i=7 r=8", out_valid8, found8, index8, run_len8);
        end
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n_out = 0;
        for (int c = 0; c < 4; c++) begin
            cycle8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (g_out) n_out++;
        end
        checks++; if (n_out != 0) begin errors++; $display("FAIL rst_stale got %0d outputs want 0", n_out); end
        cycle8(1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            cycle8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (g_out && q8.size() > 0) begin
                e = q8.pop_front();
                n_out++;
                checks++; if ({g_f, g_i, g_r} !== {1'b1, 3'd6, 4'd1}) begin
                    errors++; $display("FAIL rst_after got f=%b i=%0d r=%0d want f=1 i=6 r=1", g_f, g_i, g_r);
                end
            end
        end
        checks++; if (n_out != 1) begin errors++; $display("FAIL rst_after_count got %0d want 1", n_out); end
    endtask

    task automatic test_random32();
        int acc, stalls, k, lat, exp_lat, cyc_a, stl_a;
        logic iv, ordy, v, m;
        logic [31:0] b;
        res_t e;
        acc = 0; stalls = 0;
        for (int c = 0; c < 30000 && (acc < 1000 || q32.size() > 0); c++) begin
            iv   = (acc < 1000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            v    = 1'($urandom_range(0, 1));
            m    = 1'($urandom_range(0, 1));
            k    = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
                2:       b = 32'h8000_0000 >> k;
                default: b = $urandom_range(0, 1) ? (32'hFFFF_FFFF >> k) : ~(32'hFFFF_FFFF >> k);
            endcase
            @(negedge clk);
            in_valid32 = iv; bits32 = b; val32 = v; mode32 = hs_mode_t'(m); out_ready32 = ordy;
            #1;
            if (out_valid32 && !out_ready32) stalls++;
            if (iv && in_ready32) begin
                q32.push_back(model(b, v, m, 32)); q32_cyc.push_back(c); q32_stl.push_back(stalls); acc++;
            end
            if (out_valid32 && out_ready32) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected got i=%0d want no output", index32);
                end else begin
                    e = q32.pop_front(); cyc_a = q32_cyc.pop_front(); stl_a = q32_stl.pop_front();
                    if ({found32, 32'(index32), 32'(run_len32)} !== {e.f, e.idx, e.rl}) begin
                        errors++; $display("FAIL rnd_result got f=%b i=%0d r=%0d want f=%b i=%0d r=%0d",
                                           found32, index32, run_len32, e.f, e.idx, e.rl);
                    end
                    lat = c - cyc_a; exp_lat = 5 + stalls - stl_a;
                    checks++; if (lat != exp_lat) begin
                        errors++; $display("FAIL rnd_latency got %0d want %0d", lat, exp_lat);
                    end
                end
            end
            @(posedge clk);
        end
        in_valid32 = 1'b0;
        checks++; if (acc != 1000 || q32.size() != 0) begin
            errors++; $display("FAIL rnd_complete got %0d accepted %0d pending want 1000/0", acc, q32.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_random32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
